// File: rtl/ma_stage_pkg.sv
// Shared types for the memory-access stage: load/store width codes and FSM states.
package ma_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_WAIT  = 2'd1,
        MA_HOLD  = 2'd2,
        MA_DRAIN = 2'd3
    } ma_state_e;

endpackage

// File: rtl/ma_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module ma_load_align
    import ma_stage_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        adr,
    input  logic [2:0]        ldst_code,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{adr, 3'b000} +: 8];
        half_sel = adr[1] ? rdata[31:16] : rdata[15:0];
        case (ldst_code)
            LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
            LDST_H:  data = {{16{half_sel[15]}}, half_sel};
            LDST_BU: data = {24'h000000, byte_sel};
            LDST_HU: data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: data-bus req/ack handshake, load alignment, WB/WB2 registers.
// Optional bus-timeout abort is compiled in with MA_TIMEOUT_EN.
module ma_stage
    import ma_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned TO_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_ld_ma,
    input  logic              cmd_st_ma,
    input  logic [REG_W-1:0]  rd_adr_ma,
    input  logic [DATA_W-1:0] rd_data_ma,
    input  logic              wbk_rd_reg_ma,
    input  logic [DATA_W-1:0] st_data_ma,
    input  logic [2:0]        ldst_code_ma,
    input  logic              stall,
    input  logic              rst_pipe,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [29:0]       dmem_adr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              ma_stall,
    output logic              ma_misalign,
    output logic              ma_buserr,
    output logic [REG_W-1:0]  rd_adr_wb,
    output logic              wbk_rd_reg_wb,
    output logic [DATA_W-1:0] wbk_data_wb,
    output logic [REG_W-1:0]  rd_adr_wb2,
    output logic              wbk_rd_reg_wb2,
    output logic [DATA_W-1:0] wbk_data_wb2
);

    if ((MAX_WAIT == 0) || (MAX_WAIT >= (32'd1 << TO_W))) begin : g_cfg_check
        $error("ma_stage: MAX_WAIT must be nonzero and fit in TO_W bits");
    end

    ma_state_e         state;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] ld_data;
    logic [1:0]        adr_lo;
    logic              is_mem;
    logic              misalign;
    logic              access;
    logic              timeout;
    logic              upd;
    logic              wb_en;

    assign adr_lo = rd_data_ma[1:0];
    assign is_mem = cmd_ld_ma | cmd_st_ma;

    always_comb begin
        misalign = 1'b0;
        case (ldst_code_ma)
            LDST_H, LDST_HU: misalign = adr_lo[0];
            LDST_W:          misalign = |adr_lo;
            default:         misalign = 1'b0;
        endcase
        misalign = misalign & is_mem;
    end

    assign access   = is_mem & ~misalign;
    assign dmem_req = ((state == MA_IDLE) & access) | (state == MA_WAIT) | (state == MA_DRAIN);
    assign ma_stall = dmem_req & ~dmem_ack & ~timeout;
    assign upd      = ~stall & ~ma_stall;
    assign dmem_we  = cmd_st_ma;
    assign dmem_adr = rd_data_ma[31:2];

    // Lane enables and lane replication of store data.
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = st_data_ma;
        case (ldst_code_ma[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << adr_lo;
                dmem_wdata = {4{st_data_ma[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << {adr_lo[1], 1'b0};
                dmem_wdata = {2{st_data_ma[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = st_data_ma;
            end
        endcase
    end

    ma_load_align u_load_align (
        .rdata     (dmem_rdata),
        .adr       (adr_lo),
        .ldst_code (ldst_code_ma),
        .data      (ld_data)
    );

`ifdef MA_TIMEOUT_EN
    logic [TO_W-1:0] wait_cnt;

    assign timeout = (state == MA_WAIT) & ~dmem_ack & ~rst_pipe &
                     (wait_cnt == TO_W'(MAX_WAIT - 1));

    // Counts consecutive WAIT cycles; any exit from WAIT restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state == MA_WAIT) && !dmem_ack && !rst_pipe && !timeout) begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Drained or aborted accesses and misaligned ones never write back.
    assign wb_en = wbk_rd_reg_ma & ~misalign & ~timeout & (state != MA_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= MA_IDLE;
            hold_data      <= '0;
            rd_adr_wb      <= '0;
            wbk_rd_reg_wb  <= 1'b0;
            wbk_data_wb    <= '0;
            rd_adr_wb2     <= '0;
            wbk_rd_reg_wb2 <= 1'b0;
            wbk_data_wb2   <= '0;
            ma_misalign    <= 1'b0;
            ma_buserr      <= 1'b0;
        end else begin
            case (state)
                MA_IDLE: begin
                    if (access && !dmem_ack) begin
                        state <= rst_pipe ? MA_DRAIN : MA_WAIT;
                    end else if (access && stall && !rst_pipe) begin
                        state     <= MA_HOLD;
                        hold_data <= ld_data;
                    end
                end
                MA_WAIT: begin
                    if (rst_pipe) begin
                        state <= dmem_ack ? MA_IDLE : MA_DRAIN;
                    end else if (dmem_ack) begin
                        if (stall) begin
                            state     <= MA_HOLD;
                            hold_data <= ld_data;
                        end else begin
                            state <= MA_IDLE;
                        end
                    end else if (timeout) begin
                        state <= MA_IDLE;
                    end
                end
                MA_HOLD: begin
                    if (rst_pipe || !stall) begin
                        state <= MA_IDLE;
                    end
                end
                MA_DRAIN: begin
                    if (dmem_ack) begin
                        state <= MA_IDLE;
                    end
                end
                default: state <= MA_IDLE;
            endcase

            if (rst_pipe) begin
                rd_adr_wb      <= '0;
                wbk_rd_reg_wb  <= 1'b0;
                wbk_data_wb    <= '0;
                rd_adr_wb2     <= '0;
                wbk_rd_reg_wb2 <= 1'b0;
                wbk_data_wb2   <= '0;
                ma_misalign    <= 1'b0;
                ma_buserr      <= 1'b0;
            end else begin
                ma_misalign <= upd & misalign;
                ma_buserr   <= upd & timeout;
                if (upd) begin
                    rd_adr_wb     <= rd_adr_ma;
                    wbk_rd_reg_wb <= wb_en;
                    wbk_data_wb   <= !cmd_ld_ma          ? rd_data_ma :
                                     (state == MA_HOLD)  ? hold_data  : ld_data;
                end
                if (!stall) begin
                    rd_adr_wb2     <= rd_adr_wb;
                    wbk_rd_reg_wb2 <= wbk_rd_reg_wb;
                    wbk_data_wb2   <= wbk_data_wb;
                end
            end
        end
    end

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: stores, aligned/waited/held/drained loads, misalign, timeout.
module tb_ma_stage;
    import ma_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma, stall, rst_pipe;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma, st_data_ma, dmem_rdata, dmem_wdata, wbk_data_wb, wbk_data_wb2;
    logic [2:0]  ldst_code_ma;
    logic        dmem_req, dmem_we, dmem_ack, ma_stall, ma_misalign, ma_buserr;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_adr_wb, rd_adr_wb2;
    logic        wbk_rd_reg_wb, wbk_rd_reg_wb2;

    int n_cmp = 0;
    int n_err = 0;

    ma_stage #(.MAX_WAIT(15), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .rd_adr_ma(rd_adr_ma),
        .rd_data_ma(rd_data_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma), .st_data_ma(st_data_ma),
        .ldst_code_ma(ldst_code_ma), .stall(stall), .rst_pipe(rst_pipe),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .ma_stall(ma_stall), .ma_misalign(ma_misalign), .ma_buserr(ma_buserr),
        .rd_adr_wb(rd_adr_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb), .wbk_data_wb(wbk_data_wb),
        .rd_adr_wb2(rd_adr_wb2), .wbk_rd_reg_wb2(wbk_rd_reg_wb2), .wbk_data_wb2(wbk_data_wb2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; wbk_rd_reg_ma = 1'b0; rd_adr_ma = '0;
        rd_data_ma = '0; st_data_ma = '0; ldst_code_ma = '0; stall = 1'b0;
        rst_pipe = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if ({dmem_req, ma_stall, ma_misalign, ma_buserr} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000", {dmem_req, ma_stall, ma_misalign, ma_buserr}); end
        n_cmp++; if ({rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb} !== 38'd0) begin
            n_err++; $display("FAIL reset_wb: got %h expected 0", {rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb}); end
        n_cmp++; if ({rd_adr_wb2, wbk_rd_reg_wb2, wbk_data_wb2} !== 38'd0) begin
            n_err++; $display("FAIL reset_wb2: got %h expected 0", {rd_adr_wb2, wbk_rd_reg_wb2, wbk_data_wb2}); end
        rst_n = 1'b1;
        step();
    endtask

    // Non-memory result with an H code and odd address must not be treated as misaligned.
    task automatic test_alu();
        wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd31; rd_data_ma = 32'h1234_5679; ldst_code_ma = LDST_H;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL alu_req: got %b expected 0", dmem_req); end
        step();
        clear_inputs();
        n_cmp++; if (wbk_data_wb !== 32'h1234_5679) begin
            n_err++; $display("FAIL alu_data: got %h expected 12345679", wbk_data_wb); end
        n_cmp++; if ({rd_adr_wb, wbk_rd_reg_wb, ma_misalign} !== {5'd31, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL alu_ctl: got %b expected 1111110", {rd_adr_wb, wbk_rd_reg_wb, ma_misalign}); end
        step();
    endtask

    task automatic test_store();
        logic [31:0] s_adr [5];
        logic [31:0] s_dat [5];
        logic [2:0]  s_code [5];
        logic [3:0]  s_be [5];
        logic [31:0] s_wd [5];
        logic [29:0] s_wa [5];
        s_adr  = '{32'h103, 32'h002, 32'h008, 32'h000, 32'h100};
        s_dat  = '{32'h0000_00A5, 32'hFFFF_1234, 32'h89AB_CDEF, 32'h1234_565A, 32'h0000_BEEF};
        s_code = '{LDST_B, LDST_H, LDST_W, LDST_B, LDST_H};
        s_be   = '{4'b1000, 4'b1100, 4'b1111, 4'b0001, 4'b0011};
        s_wd   = '{32'hA5A5_A5A5, 32'h1234_1234, 32'h89AB_CDEF, 32'h5A5A_5A5A, 32'hBEEF_BEEF};
        s_wa   = '{30'h40, 30'h0, 30'h2, 30'h0, 30'h40};
        for (int i = 0; i < 5; i++) begin
            cmd_st_ma = 1'b1; rd_data_ma = s_adr[i]; st_data_ma = s_dat[i];
            ldst_code_ma = s_code[i]; dmem_ack = 1'b1;
            #1;
            n_cmp++; if ({dmem_req, dmem_we, ma_stall} !== 3'b110) begin
                n_err++; $display("FAIL store_req[%0d]: got %b expected 110", i, {dmem_req, dmem_we, ma_stall}); end
            n_cmp++; if (dmem_be !== s_be[i]) begin
                n_err++; $display("FAIL store_be[%0d]: got %b expected %b", i, dmem_be, s_be[i]); end
            n_cmp++; if (dmem_wdata !== s_wd[i]) begin
                n_err++; $display("FAIL store_wdata[%0d]: got %h expected %h", i, dmem_wdata, s_wd[i]); end
            n_cmp++; if (dmem_adr !== s_wa[i]) begin
                n_err++; $display("FAIL store_adr[%0d]: got %h expected %h", i, dmem_adr, s_wa[i]); end
            step();
        end
        clear_inputs();
        step();
    endtask

    // Zero-wait loads issued every cycle; WB2 trails WB by one instruction.
    task automatic test_back_to_back();
        logic [31:0] l_adr [5];
        logic [31:0] l_rd [5];
        logic [2:0]  l_code [5];
        logic [31:0] l_exp [5];
        l_adr  = '{32'h0, 32'h2, 32'h4, 32'h1, 32'h3};
        l_rd   = '{32'h1234_8001, 32'h8001_7FFF, 32'hCAFE_F00D, 32'h0000_7F00, 32'hFF00_0000};
        l_code = '{LDST_H, LDST_HU, LDST_W, LDST_B, LDST_BU};
        l_exp  = '{32'hFFFF_8001, 32'h0000_8001, 32'hCAFE_F00D, 32'h0000_007F, 32'h0000_00FF};
        for (int i = 0; i < 5; i++) begin
            cmd_ld_ma = 1'b1; wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'(10 + i);
            rd_data_ma = l_adr[i]; ldst_code_ma = l_code[i]; dmem_rdata = l_rd[i]; dmem_ack = 1'b1;
            #1;
            n_cmp++; if ({dmem_req, ma_stall} !== 2'b10) begin
                n_err++; $display("FAIL b2b_req[%0d]: got %b expected 10", i, {dmem_req, ma_stall}); end
            step();
            n_cmp++; if (wbk_data_wb !== l_exp[i]) begin
                n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, wbk_data_wb, l_exp[i]); end
            if (i > 0) begin
                n_cmp++; if (wbk_data_wb2 !== l_exp[i-1]) begin
                    n_err++; $display("FAIL b2b_wb2[%0d]: got %h expected %h", i, wbk_data_wb2, l_exp[i-1]); end
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_load_wait();
        logic [2:0]  w_code [2];
        logic [31:0] w_exp [2];
        int          stall_cnt;
        w_code = '{LDST_B, LDST_BU};
        w_exp  = '{32'hFFFF_FF80, 32'h0000_0080};
        for (int i = 0; i < 2; i++) begin
            cmd_ld_ma = 1'b1; wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd5; rd_data_ma = 32'h102;
            ldst_code_ma = w_code[i]; dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
            stall_cnt = 0;
            for (int c = 0; c < 3; c++) begin
                #1;
                if (ma_stall === 1'b1) stall_cnt++;
                step();
            end
            dmem_ack = 1'b1; dmem_rdata = 32'h0080_0000;
            #1;
            n_cmp++; if (ma_stall !== 1'b0) begin
                n_err++; $display("FAIL wait_ack_stall[%0d]: got %b expected 0", i, ma_stall); end
            step();
            clear_inputs();
            n_cmp++; if (stall_cnt != 3) begin
                n_err++; $display("FAIL wait_stall_cycles[%0d]: got %0d expected 3", i, stall_cnt); end
            n_cmp++; if (wbk_data_wb !== w_exp[i]) begin
                n_err++; $display("FAIL wait_data[%0d]: got %h expected %h", i, wbk_data_wb, w_exp[i]); end
            n_cmp++; if ({rd_adr_wb, wbk_rd_reg_wb} !== {5'd5, 1'b1}) begin
                n_err++; $display("FAIL wait_ctl[%0d]: got %b expected 001011", i, {rd_adr_wb, wbk_rd_reg_wb}); end
            step();
        end
    endtask

    task automatic test_misalign();
        cmd_ld_ma = 1'b1; wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd7; rd_data_ma = 32'h102; ldst_code_ma = LDST_W;
        #1;
        n_cmp++; if ({dmem_req, ma_stall} !== 2'b00) begin
            n_err++; $display("FAIL mis_lw_req: got %b expected 00", {dmem_req, ma_stall}); end
        step();
        clear_inputs();
        n_cmp++; if ({ma_misalign, wbk_rd_reg_wb, rd_adr_wb} !== {1'b1, 1'b0, 5'd7}) begin
            n_err++; $display("FAIL mis_lw_wb: got %b expected 1000111", {ma_misalign, wbk_rd_reg_wb, rd_adr_wb}); end
        step();
        n_cmp++; if (ma_misalign !== 1'b0) begin
            n_err++; $display("FAIL mis_pulse_width: got %b expected 0", ma_misalign); end
        cmd_st_ma = 1'b1; rd_data_ma = 32'h1; ldst_code_ma = LDST_H;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL mis_sh_req: got %b expected 0", dmem_req); end
        step();
        clear_inputs();
        n_cmp++; if (ma_misalign !== 1'b1) begin n_err++; $display("FAIL mis_sh_pulse: got %b expected 1", ma_misalign); end
        step();
    endtask

    task automatic test_hold();
        cmd_ld_ma = 1'b1; wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd9; rd_data_ma = 32'h2; ldst_code_ma = LDST_HU;
        #1;
        n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL hold_req: got %b expected 1", dmem_req); end
        step();
        stall = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hBEEF_0000;
        #1;
        n_cmp++; if (ma_stall !== 1'b0) begin n_err++; $display("FAIL hold_ack_stall: got %b expected 0", ma_stall); end
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'h1111_2222;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL hold_no_rereq: got %b expected 0", dmem_req); end
        step();
        n_cmp++; if (wbk_data_wb !== 32'h0) begin
            n_err++; $display("FAIL hold_early_wb: got %h expected 00000000", wbk_data_wb); end
        stall = 1'b0;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL hold_release_req: got %b expected 0", dmem_req); end
        step();
        clear_inputs();
        n_cmp++; if ({wbk_data_wb, rd_adr_wb, wbk_rd_reg_wb} !== {32'h0000_BEEF, 5'd9, 1'b1}) begin
            n_err++; $display("FAIL hold_wb: got %h expected 0000beef/9/1", {wbk_data_wb, rd_adr_wb, wbk_rd_reg_wb}); end
        step();
        n_cmp++; if ({wbk_data_wb2, rd_adr_wb2, wbk_rd_reg_wb2} !== {32'h0000_BEEF, 5'd9, 1'b1}) begin
            n_err++; $display("FAIL hold_wb2: got %h expected 0000beef/9/1", {wbk_data_wb2, rd_adr_wb2, wbk_rd_reg_wb2}); end
        step();
    endtask

    task automatic test_drain();
        wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd4; rd_data_ma = 32'h55;
        step();
        cmd_ld_ma = 1'b1; rd_adr_ma = 5'd3; rd_data_ma = 32'h10; ldst_code_ma = LDST_W;
        #1;
        n_cmp++; if (ma_stall !== 1'b1) begin n_err++; $display("FAIL drain_first_stall: got %b expected 1", ma_stall); end
        step();
        n_cmp++; if ({wbk_data_wb, wbk_data_wb2} !== {32'h55, 32'h55}) begin
            n_err++; $display("FAIL drain_pre_wb: got %h expected 55/55", {wbk_data_wb, wbk_data_wb2}); end
        rst_pipe = 1'b1;
        step();
        rst_pipe = 1'b0;
        n_cmp++; if ({wbk_data_wb, wbk_data_wb2, rd_adr_wb, wbk_rd_reg_wb} !== 70'd0) begin
            n_err++; $display("FAIL drain_flush_wb: got %h expected 0", {wbk_data_wb, wbk_data_wb2, rd_adr_wb, wbk_rd_reg_wb}); end
        #1;
        n_cmp++; if ({dmem_req, ma_stall} !== 2'b11) begin
            n_err++; $display("FAIL drain_req_held: got %b expected 11", {dmem_req, ma_stall}); end
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if ({dmem_req, ma_stall} !== 2'b10) begin
            n_err++; $display("FAIL drain_ack: got %b expected 10", {dmem_req, ma_stall}); end
        step();
        clear_inputs();
        #1;
        n_cmp++; if ({dmem_req, wbk_rd_reg_wb} !== 2'b00) begin
            n_err++; $display("FAIL drain_done: got %b expected 00", {dmem_req, wbk_rd_reg_wb}); end
        step();
    endtask

`ifdef MA_TIMEOUT_EN
    task automatic test_timeout();
        int stall_cnt;
        cmd_ld_ma = 1'b1; wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd6; rd_data_ma = 32'h20; ldst_code_ma = LDST_W;
        stall_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ma_stall !== 1'b1) break;
            stall_cnt++;
            step();
        end
        n_cmp++; if (stall_cnt != 15) begin
            n_err++; $display("FAIL timeout_cycles: got %0d expected 15", stall_cnt); end
        step();
        clear_inputs();
        #1;
        n_cmp++; if ({dmem_req, ma_stall, ma_buserr, wbk_rd_reg_wb} !== 4'b0010) begin
            n_err++; $display("FAIL timeout_abort: got %b expected 0010", {dmem_req, ma_stall, ma_buserr, wbk_rd_reg_wb}); end
        step();
        n_cmp++; if (ma_buserr !== 1'b0) begin n_err++; $display("FAIL timeout_pulse: got %b expected 0", ma_buserr); end
    endtask
`else
    task automatic test_long_wait();
        int stall_cnt;
        int err_seen;
        cmd_ld_ma = 1'b1; wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd6; rd_data_ma = 32'h40; ldst_code_ma = LDST_W;
        stall_cnt = 0; err_seen = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ma_stall === 1'b1) stall_cnt++;
            if (ma_buserr !== 1'b0) err_seen++;
            step();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        step();
        clear_inputs();
        n_cmp++; if (stall_cnt != 20 || err_seen != 0) begin
            n_err++; $display("FAIL long_wait_stall: got %0d stalls %0d buserr expected 20/0", stall_cnt, err_seen); end
        n_cmp++; if ({wbk_data_wb, wbk_rd_reg_wb} !== {32'h0BAD_F00D, 1'b1}) begin
            n_err++; $display("FAIL long_wait_data: got %h expected 0badf00d/1", {wbk_data_wb, wbk_rd_reg_wb}); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_back_to_back();
        test_load_wait();
        test_misalign();
        test_hold();
        test_drain();
`ifdef MA_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
